dyser_conf_loader: RTL and testbench

//  Sequences configuration of a DySER fabric. It accepts a stream of 32-bit configuration words from the host

---
 rtl/dyser_conf_loader_pkg.sv | 23 ++
 rtl/dyser_conf_loader.sv | 119 +++++++++++
 tb/tb_dyser_conf_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dyser_conf_loader_pkg.sv
// Shared widths, loader state encoding and chain-word packing for the DySER configuration loader.
package dyser_conf_loader_pkg;

    // Fabric datapath geometry: a chain word is the 32-bit payload followed by the meta bits.
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned META_BITS  = 2;
    localparam int unsigned PATH_WIDTH = DATA_WIDTH + META_BITS - 1;
    localparam int unsigned CONF_W     = PATH_WIDTH + 1;

    // Loader sequencing states.
    typedef enum logic [1:0] {
        CL_IDLE      = 2'd0,
        CL_WAIT_IDLE = 2'd1,
        CL_SHIFT     = 2'd2,
        CL_SETTLE    = 2'd3
    } cl_state_e;

    // Place a host word at the chain head with zeroed meta bits.
    function automatic logic [CONF_W-1:0] conf_pack(input logic [DATA_WIDTH-1:0] word);
        return {word, {META_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/dyser_conf_loader.sv
// Streams host configuration words into the DySER SE chain once the fabric is quiescent,
// counting words up to the chain length and reporting completion or abort.
module dyser_conf_loader
    import dyser_conf_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 48,
    parameter int unsigned CNT_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic [DATA_WIDTH-1:0] cfg_word_in,
    input  logic                  cfg_valid_in,
    output logic                  cfg_ready_out,
    input  logic                  fabric_idle,
    output logic                  conf_en,
    output logic [CONF_W-1:0]     conf_data_out,
    output logic                  busy,
    output logic                  cfg_done,
    output logic                  cfg_aborted,
    output logic [CNT_W-1:0]      words_loaded
);

    cl_state_e          state_q;
    logic               conf_en_q;
    logic [CONF_W-1:0]  conf_data_q;
    logic               busy_q;
    logic               cfg_done_q;
    logic               cfg_aborted_q;
    logic [CNT_W-1:0]   words_q;
    logic [CNT_W-1:0]   words_d;
    logic               last_word;

    // Incremented count and detection of the word that completes the chain.
    assign words_d   = words_q + CNT_W'(1);
    assign last_word = (words_q == CNT_W'(CHAIN_LEN - 1));

    // Loader FSM with registered shift enable, chain data, status pulses and word counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= CL_IDLE;
            conf_en_q     <= 1'b0;
            conf_data_q   <= '0;
            busy_q        <= 1'b0;
            cfg_done_q    <= 1'b0;
            cfg_aborted_q <= 1'b0;
            words_q       <= '0;
        end else begin
            // Shift enable and status flags are single-cycle unless re-armed below.
            conf_en_q     <= 1'b0;
            cfg_done_q    <= 1'b0;
            cfg_aborted_q <= 1'b0;

            case (state_q)
                CL_IDLE: begin
                    // A start coinciding with abort is discarded.
                    if (cfg_start && !cfg_abort) begin
                        state_q <= CL_WAIT_IDLE;
                        busy_q  <= 1'b1;
                        words_q <= '0;
                    end
                end

                CL_WAIT_IDLE: begin
                    if (cfg_abort) begin
                        state_q       <= CL_IDLE;
                        busy_q        <= 1'b0;
                        cfg_aborted_q <= 1'b1;
                    end else if (fabric_idle) begin
                        state_q <= CL_SHIFT;
                    end
                end

                CL_SHIFT: begin
                    // Abort takes priority over a word offered in the same cycle.
                    if (cfg_abort) begin
                        state_q       <= CL_IDLE;
                        busy_q        <= 1'b0;
                        cfg_aborted_q <= 1'b1;
                    end else if (cfg_valid_in) begin
                        conf_en_q   <= 1'b1;
                        conf_data_q <= conf_pack(cfg_word_in);
                        words_q     <= words_d;
                        if (last_word) begin
                            state_q <= CL_SETTLE;
                        end
                    end
                end

                CL_SETTLE: begin
                    // The final shift is on the wire this cycle; report completion next.
                    state_q <= CL_IDLE;
                    busy_q  <= 1'b0;
                    if (cfg_abort) begin
                        cfg_aborted_q <= 1'b1;
                    end else begin
                        cfg_done_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= CL_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Ready is a pure decode of the state register so it never depends on host valid.
    assign cfg_ready_out = (state_q == CL_SHIFT);
    assign conf_en       = conf_en_q;
    assign conf_data_out = conf_data_q;
    assign busy          = busy_q;
    assign cfg_done      = cfg_done_q;
    assign cfg_aborted   = cfg_aborted_q;
    assign words_loaded  = words_q;

endmodule

// File: tb/tb_dyser_conf_loader.sv
// Directed vector bench for dyser_conf_loader with a 4-word chain.
module tb_dyser_conf_loader;
    import dyser_conf_loader_pkg::*;

    localparam int unsigned CL = 4;
    localparam int unsigned CW = 3;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cfg_start = 1'b0;
    logic                  cfg_abort = 1'b0;
    logic [DATA_WIDTH-1:0] cfg_word_in = '0;
    logic                  cfg_valid_in = 1'b0;
    logic                  cfg_ready_out;
    logic                  fabric_idle = 1'b0;
    logic                  conf_en;
    logic [CONF_W-1:0]     conf_data_out;
    logic                  busy;
    logic                  cfg_done;
    logic                  cfg_aborted;
    logic [CW-1:0]         words_loaded;

    int n_cmp = 0;
    int n_err = 0;

    dyser_conf_loader #(.CHAIN_LEN(CL), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .cfg_word_in   (cfg_word_in),
        .cfg_valid_in  (cfg_valid_in),
        .cfg_ready_out (cfg_ready_out),
        .fabric_idle   (fabric_idle),
        .conf_en       (conf_en),
        .conf_data_out (conf_data_out),
        .busy          (busy),
        .cfg_done      (cfg_done),
        .cfg_aborted   (cfg_aborted),
        .words_loaded  (words_loaded)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs required right after the following edge.
    typedef struct {
        string       tag;
        logic        st;
        logic        ab;
        logic        v;
        logic        idle;
        logic [31:0] w;
        logic        rdy;
        logic        en;
        logic [31:0] dw;
        logic        busy;
        logic        done;
        logic        abt;
        logic [CW-1:0] wl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string tag, input logic st, ab, v, idle, input logic [31:0] w,
                                input logic rdy, en, input logic [31:0] dw,
                                input logic bsy, done, abt, input int wl);
        vec_t r;
        r.tag = tag; r.st = st; r.ab = ab; r.v = v; r.idle = idle; r.w = w;
        r.rdy = rdy; r.en = en; r.dw = dw; r.busy = bsy; r.done = done; r.abt = abt;
        r.wl = CW'(wl);
        return r;
    endfunction

    task automatic chk(input string tag, input string sig, input logic [33:0] act, input logic [33:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h expected %h (t=%0t)", tag, sig, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [33:0] exp_data;
        cfg_start    = v.st;
        cfg_abort    = v.ab;
        cfg_valid_in = v.v;
        fabric_idle  = v.idle;
        cfg_word_in  = v.w;
        @(posedge clk);
        #1;
        exp_data = {v.dw, 2'b00};
        chk(v.tag, "ready",   34'(cfg_ready_out), 34'(v.rdy));
        chk(v.tag, "conf_en", 34'(conf_en),       34'(v.en));
        chk(v.tag, "data",    34'(conf_data_out), exp_data);
        chk(v.tag, "busy",    34'(busy),          34'(v.busy));
        chk(v.tag, "done",    34'(cfg_done),      34'(v.done));
        chk(v.tag, "aborted", 34'(cfg_aborted),   34'(v.abt));
        chk(v.tag, "words",   34'(words_loaded),  34'(v.wl));
    endtask

    // Four back-to-back words from SHIFT; the last one lands in SETTLE.
    task automatic shift4(input string tag, input logic [31:0] base, input logic idle);
        for (int i = 0; i < 4; i++) begin
            apply(mk(tag, 1'b0, 1'b0, 1'b1, idle, base + 32'(i),
                     (i < 3), 1'b1, base + 32'(i), 1'b1, 1'b0, 1'b0, i + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Full load followed by a load with host bubbles 1,0,0,1,1,0,1.
        tbl.push_back(mk("full_start", 1,0,0,1, 32'h0,   0,0,32'h0,  1,0,0,0));
        tbl.push_back(mk("full_wait",  0,0,0,1, 32'h0,   1,0,32'h0,  1,0,0,0));
        tbl.push_back(mk("full_w1",    0,0,1,1, 32'h11,  1,1,32'h11, 1,0,0,1));
        tbl.push_back(mk("full_w2",    0,0,1,1, 32'h22,  1,1,32'h22, 1,0,0,2));
        tbl.push_back(mk("full_w3",    0,0,1,1, 32'h33,  1,1,32'h33, 1,0,0,3));
        tbl.push_back(mk("full_w4",    0,0,1,1, 32'h44,  0,1,32'h44, 1,0,0,4));
        tbl.push_back(mk("full_done",  0,0,0,1, 32'h0,   0,0,32'h44, 0,1,0,4));
        tbl.push_back(mk("full_after", 0,0,0,1, 32'h0,   0,0,32'h44, 0,0,0,4));
        tbl.push_back(mk("bub_start",  1,0,0,1, 32'h0,   0,0,32'h44, 1,0,0,0));
        tbl.push_back(mk("bub_wait",   0,0,0,1, 32'h0,   1,0,32'h44, 1,0,0,0));
        tbl.push_back(mk("bub_v1",     0,0,1,1, 32'hA1,  1,1,32'hA1, 1,0,0,1));
        tbl.push_back(mk("bub_v0a",    0,0,0,1, 32'hBAD, 1,0,32'hA1, 1,0,0,1));
        tbl.push_back(mk("bub_v0b",    0,0,0,1, 32'hBAD, 1,0,32'hA1, 1,0,0,1));
        tbl.push_back(mk("bub_v1b",    0,0,1,1, 32'hA2,  1,1,32'hA2, 1,0,0,2));
        tbl.push_back(mk("bub_v1c",    0,0,1,1, 32'hA3,  1,1,32'hA3, 1,0,0,3));
        tbl.push_back(mk("bub_v0c",    0,0,0,1, 32'hDEAD,1,0,32'hA3, 1,0,0,3));
        tbl.push_back(mk("bub_v1d",    0,0,1,1, 32'hA4,  0,1,32'hA4, 1,0,0,4));
        tbl.push_back(mk("bub_done",   0,0,0,1, 32'h0,   0,0,32'hA4, 0,1,0,4));
        tbl.push_back(mk("bub_idle_v", 0,0,1,1, 32'h55,  0,0,32'hA4, 0,0,0,4));

        // Reset held three cycles with start and valid asserted.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(mk("reset", 1,0,1,1, 32'hFFFF_FFFF, 0,0,32'h0, 0,0,0,0));
        end
        rst_n = 1'b1;
        apply(mk("post_reset", 0,0,0,1, 32'h0, 0,0,32'h0, 0,0,0,0));

        foreach (tbl[i]) apply(tbl[i]);

        // Quiesce wait: fabric busy for several cycles, then idle; idle later drops mid-shift.
        apply(mk("q_start", 1,0,0,0, 32'h0, 0,0,32'hA4, 1,0,0,0));
        for (int i = 0; i < 5; i++) begin
            apply(mk("q_wait", 0,0,1,0, 32'h99, 0,0,32'hA4, 1,0,0,0));
        end
        apply(mk("q_rise", 0,0,0,1, 32'h0, 1,0,32'hA4, 1,0,0,0));
        shift4("q_shift", 32'hB1, 1'b0);
        apply(mk("q_done", 0,0,0,0, 32'h0, 0,0,32'hB4, 0,1,0,4));

        // Abort offered with word 3; start during SHIFT is ignored.
        apply(mk("a_start", 1,0,0,1, 32'h0,  0,0,32'hB4, 1,0,0,0));
        apply(mk("a_wait",  0,0,0,1, 32'h0,  1,0,32'hB4, 1,0,0,0));
        apply(mk("a_w1",    0,0,1,1, 32'hC1, 1,1,32'hC1, 1,0,0,1));
        apply(mk("a_w2_st", 1,0,1,1, 32'hC2, 1,1,32'hC2, 1,0,0,2));
        apply(mk("a_w3_ab", 0,1,1,1, 32'hC3, 0,0,32'hC2, 0,0,1,2));
        apply(mk("a_after", 0,0,0,1, 32'h0,  0,0,32'hC2, 0,0,0,2));

        // Controls ignored in IDLE.
        apply(mk("i_abort", 0,1,0,1, 32'h0, 0,0,32'hC2, 0,0,0,2));
        apply(mk("i_st_ab", 1,1,0,1, 32'h0, 0,0,32'hC2, 0,0,0,2));
        apply(mk("i_hold",  0,0,0,1, 32'h0, 0,0,32'hC2, 0,0,0,2));

        // Reload after abort restarts the count from zero.
        apply(mk("r_start", 1,0,0,1, 32'h0, 0,0,32'hC2, 1,0,0,0));
        apply(mk("r_wait",  0,0,0,1, 32'h0, 1,0,32'hC2, 1,0,0,0));
        shift4("r_shift", 32'hD1, 1'b1);
        apply(mk("r_done",  0,0,0,1, 32'h0, 0,0,32'hD4, 0,1,0,4));

        // Abort while waiting for quiesce beats a simultaneous idle.
        apply(mk("w_start", 1,0,0,0, 32'h0, 0,0,32'hD4, 1,0,0,0));
        apply(mk("w_abort", 0,1,0,1, 32'h0, 0,0,32'hD4, 0,0,1,0));
        apply(mk("w_after", 0,0,0,1, 32'h0, 0,0,32'hD4, 0,0,0,0));

        // Abort during SETTLE suppresses done.
        apply(mk("s_start", 1,0,0,1, 32'h0, 0,0,32'hD4, 1,0,0,0));
        apply(mk("s_wait",  0,0,0,1, 32'h0, 1,0,32'hD4, 1,0,0,0));
        shift4("s_shift", 32'hE1, 1'b1);
        apply(mk("s_abort", 0,1,0,1, 32'h0, 0,0,32'hE4, 0,0,1,4));
        apply(mk("s_after", 0,0,0,1, 32'h0, 0,0,32'hE4, 0,0,0,4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
